password_lock_fsm: RTL and testbench



---
 rtl/pw_lock_pkg.sv | 24 ++
 rtl/pw_digit_collector.sv | 49 ++++
 rtl/password_lock_fsm.sv | 150 +++++++++++++++
 tb/tb_password_lock_fsm.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pw_lock_pkg.sv
// Shared types and default geometry for the multi-digit password lock.
// The top-level module derives its own widths from its parameters.
package pw_lock_pkg;

  localparam int DEF_DIGIT_W        = 4;
  localparam int DEF_NUM_DIGITS     = 4;
  localparam int DEF_MAX_ATTEMPTS   = 3;
  localparam int DEF_LOCKOUT_CYCLES = 16;

  localparam int CODE_W = DEF_DIGIT_W * DEF_NUM_DIGITS;
  localparam int ATT_W  = $clog2(DEF_MAX_ATTEMPTS + 1);
  localparam int LCK_W  = $clog2(DEF_LOCKOUT_CYCLES + 1);

  localparam logic [CODE_W-1:0] DEF_CODE = 16'hB0B1;

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    GRANT,
    LOCKOUT,
    NEW_CODE
  } state_e;

endpackage

// File: rtl/pw_digit_collector.sv
// Digit shift register and counter shared by code entry and code change.
// done_o and code_d_o are combinational so the caller can act on the accepting edge.
module pw_digit_collector #(
  parameter int DIGIT_W    = 4,
  parameter int NUM_DIGITS = 4,
  parameter int CNT_W      = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          shift_en_i,
  input  logic                          clr_i,
  input  logic [DIGIT_W-1:0]            digit_i,
  output logic [DIGIT_W*NUM_DIGITS-1:0] code_d_o,
  output logic [CNT_W-1:0]              count_o,
  output logic                          done_o
);

  localparam int CW = DIGIT_W * NUM_DIGITS;

  logic [CW-1:0]    shreg_q;
  logic [CNT_W-1:0] count_q;

  generate
    if (NUM_DIGITS == 1) begin : g_single
      assign code_d_o = digit_i;
    end else begin : g_multi
      assign code_d_o = {shreg_q[CW-DIGIT_W-1:0], digit_i};
    end
  endgenerate

  assign done_o  = shift_en_i && (count_q == CNT_W'(NUM_DIGITS - 1));
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (shift_en_i) begin
      shreg_q <= code_d_o;
    end
  end

  // The counter wraps to zero on the final digit, so a complete entry never shows NUM_DIGITS.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      count_q <= '0;
    end else if (shift_en_i) begin
      count_q <= done_o ? '0 : count_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/password_lock_fsm.sv
// Multi-digit password checker with attempt counting, timed lockout and
// in-place code change after a successful unlock.
module password_lock_fsm
  import pw_lock_pkg::*;
#(
  parameter int DIGIT_W        = DEF_DIGIT_W,
  parameter int NUM_DIGITS     = DEF_NUM_DIGITS,
  parameter int MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0] DEFAULT_CODE = DEF_CODE
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [DIGIT_W-1:0]                    digit_in,
  input  logic                                  digit_valid,
  input  logic                                  clear,
  input  logic                                  change_req,
  output logic                                  access_granted,
  output logic                                  error,
  output logic                                  locked,
  output logic                                  code_updated,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]     attempts_left,
  output logic [$clog2(NUM_DIGITS+1)-1:0]       digit_count,
  output logic [$clog2(LOCKOUT_CYCLES+1)-1:0]   lock_remaining
);

  localparam int CW  = DIGIT_W * NUM_DIGITS;
  localparam int AW  = $clog2(MAX_ATTEMPTS + 1);
  localparam int LW  = $clog2(LOCKOUT_CYCLES + 1);
  localparam int DCW = $clog2(NUM_DIGITS + 1);

  state_e         state_q;
  logic [CW-1:0]  code_q;
  logic [AW-1:0]  att_q;
  logic [LW-1:0]  lck_q;
  logic           lck_hold_q;
  logic           granted_q;
  logic           error_q;
  logic           locked_q;
  logic           upd_q;

  logic           collecting;
  logic           shift_en;
  logic           col_clr;
  logic           col_done;
  logic [CW-1:0]  entry_d;
  logic [DCW-1:0] col_count;

  assign collecting = (state_q == IDLE) || (state_q == ENTRY) || (state_q == NEW_CODE);
  assign shift_en   = collecting && digit_valid && !clear;
  assign col_clr    = collecting && clear;

  pw_digit_collector #(
    .DIGIT_W    (DIGIT_W),
    .NUM_DIGITS (NUM_DIGITS),
    .CNT_W      (DCW)
  ) u_collector (
    .clk        (clk),
    .reset      (reset),
    .shift_en_i (shift_en),
    .clr_i      (col_clr),
    .digit_i    (digit_in),
    .code_d_o   (entry_d),
    .count_o    (col_count),
    .done_o     (col_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      code_q     <= DEFAULT_CODE;
      att_q      <= AW'(MAX_ATTEMPTS);
      lck_q      <= '0;
      lck_hold_q <= 1'b0;
      granted_q  <= 1'b0;
      error_q    <= 1'b0;
      locked_q   <= 1'b0;
      upd_q      <= 1'b0;
    end else begin
      granted_q <= 1'b0;
      error_q   <= 1'b0;
      upd_q     <= 1'b0;
      case (state_q)
        IDLE, ENTRY: begin
          if (clear) begin
            state_q <= IDLE;
          end else if (shift_en) begin
            if (!col_done) begin
              state_q <= ENTRY;
            end else if (entry_d == code_q) begin
              granted_q <= 1'b1;
              att_q     <= AW'(MAX_ATTEMPTS);
              state_q   <= GRANT;
            end else begin
              error_q <= 1'b1;
              if (att_q <= AW'(1)) begin
                att_q      <= '0;
                locked_q   <= 1'b1;
                lck_q      <= LW'(LOCKOUT_CYCLES);
                lck_hold_q <= 1'b1;
                state_q    <= LOCKOUT;
              end else begin
                att_q   <= att_q - AW'(1);
                state_q <= IDLE;
              end
            end
          end
        end
        GRANT: begin
          state_q <= change_req ? NEW_CODE : IDLE;
        end
        NEW_CODE: begin
          if (clear) begin
            state_q <= IDLE;
          end else if (col_done) begin
            code_q  <= entry_d;
            upd_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        LOCKOUT: begin
          // The error cycle and the first lockout cycle both show the full count,
          // which keeps locked high for LOCKOUT_CYCLES+1 cycles in total.
          if (lck_hold_q) begin
            lck_hold_q <= 1'b0;
          end else if (lck_q <= LW'(1)) begin
            lck_q    <= '0;
            locked_q <= 1'b0;
            att_q    <= AW'(MAX_ATTEMPTS);
            state_q  <= IDLE;
          end else begin
            lck_q <= lck_q - LW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign access_granted = granted_q;
  assign error          = error_q;
  assign locked         = locked_q;
  assign code_updated   = upd_q;
  assign attempts_left  = att_q;
  assign digit_count    = col_count;
  assign lock_remaining = lck_q;

endmodule

// File: tb/tb_password_lock_fsm.sv
// Directed bench for password_lock_fsm with a cycle-level reference model
// built from digit queues and lockout start times.
module tb_password_lock_fsm;

  localparam int DW = 4;
  localparam int ND = 4;
  localparam int MA = 3;
  localparam int LC = 16;
  localparam logic [15:0] DEF = 16'hB0B1;

  logic       clk;
  logic       reset;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       clear;
  logic       change_req;
  logic       access_granted;
  logic       error;
  logic       locked;
  logic       code_updated;
  logic [1:0] attempts_left;
  logic [2:0] digit_count;
  logic [4:0] lock_remaining;

  password_lock_fsm #(
    .DIGIT_W        (DW),
    .NUM_DIGITS     (ND),
    .MAX_ATTEMPTS   (MA),
    .LOCKOUT_CYCLES (LC),
    .DEFAULT_CODE   (DEF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .digit_in       (digit_in),
    .digit_valid    (digit_valid),
    .clear          (clear),
    .change_req     (change_req),
    .access_granted (access_granted),
    .error          (error),
    .locked         (locked),
    .code_updated   (code_updated),
    .attempts_left  (attempts_left),
    .digit_count    (digit_count),
    .lock_remaining (lock_remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int lk_cnt  = 0;

  // Reference model state
  int          cyc = 0;
  int          lock_start = -1;
  bit          grant_prev = 0;
  bit          changing = 0;
  int          q[$];
  logic [15:0] m_code = DEF;
  int          m_att = MA;
  int          e_gr, e_err, e_upd, e_locked, e_att, e_cnt, e_lrem;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic m_update(input bit dv, input logic [3:0] d, input bit clr, input bit chg, input bit rst);
    logic [15:0] acc;
    bit grant_next;
    cyc++;
    grant_next = 0;
    e_gr = 0; e_err = 0; e_upd = 0;
    if (rst) begin
      q.delete();
      m_code = DEF; m_att = MA; lock_start = -1; changing = 0;
    end else if (lock_start >= 0) begin
      if (cyc - lock_start >= LC + 1) begin
        lock_start = -1;
        m_att = MA;
      end
    end else if (grant_prev) begin
      changing = chg;
    end else if (clr) begin
      q.delete();
      changing = 0;
    end else if (dv) begin
      q.push_back(int'(d));
      if (q.size() == ND) begin
        acc = '0;
        foreach (q[i]) acc = {acc[11:0], 4'(q[i])};
        if (changing) begin
          m_code = acc; e_upd = 1; changing = 0;
        end else if (acc == m_code) begin
          e_gr = 1; m_att = MA; grant_next = 1;
        end else begin
          e_err = 1; m_att--;
          if (m_att == 0) lock_start = cyc;
        end
        q.delete();
      end
    end
    grant_prev = grant_next;
    e_cnt    = q.size();
    e_att    = m_att;
    e_locked = (lock_start >= 0) ? 1 : 0;
    if (lock_start < 0) e_lrem = 0;
    else if (cyc == lock_start) e_lrem = LC;
    else e_lrem = LC - (cyc - lock_start) + 1;
  endtask

  task automatic step(input bit dv, input logic [3:0] d, input bit clr, input bit chg, input bit rst);
    @(negedge clk);
    digit_valid = dv; digit_in = d; clear = clr; change_req = chg; reset = rst;
    @(posedge clk);
    m_update(dv, d, clr, chg, rst);
    #1;
    chk("access_granted", 32'(access_granted), 32'(e_gr));
    chk("error",          32'(error),          32'(e_err));
    chk("code_updated",   32'(code_updated),   32'(e_upd));
    chk("locked",         32'(locked),         32'(e_locked));
    chk("attempts_left",  32'(attempts_left),  32'(e_att));
    chk("digit_count",    32'(digit_count),    32'(e_cnt));
    chk("lock_remaining", 32'(lock_remaining), 32'(e_lrem));
    if (locked === 1'b1) lk_cnt++;
  endtask

  task automatic idle();
    step(0, 4'h0, 0, 0, 0);
  endtask

  task automatic enter(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) step(1, c[i*4 +: 4], 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; digit_in = '0; digit_valid = 1'b0; clear = 1'b0; change_req = 1'b0;

    // Reset state
    step(0, 4'h0, 0, 0, 1);
    step(0, 4'h0, 0, 0, 1);
    chk("reset_attempts", 32'(attempts_left), 32'd3);
    chk("reset_locked", 32'(locked), 32'd0);
    idle();

    // Correct default code
    enter(16'hB0B1);
    chk("grant_pulse", 32'(access_granted), 32'd1);
    idle();
    chk("grant_one_cycle", 32'(access_granted), 32'd0);

    // Three wrong codes trigger lockout; correct code ignored while locked
    enter(16'h0000);
    chk("att_after_1st", 32'(attempts_left), 32'd2);
    enter(16'h0000);
    chk("att_after_2nd", 32'(attempts_left), 32'd1);
    lk_cnt = 0;
    enter(16'h0000);
    chk("locked_on_3rd_error", 32'(locked), 32'd1);
    chk("error_on_3rd", 32'(error), 32'd1);
    chk("lrem_at_lock", 32'(lock_remaining), 32'd16);
    enter(16'hB0B1);
    for (int k = 0; k < 40 && e_locked != 0; k++) idle();
    chk("lock_released", 32'(locked), 32'd0);
    chk("locked_cycles", 32'(lk_cnt), 32'd17);
    chk("att_after_lockout", 32'(attempts_left), 32'd3);
    idle();

    // Clear mid-entry, then correct code
    step(1, 4'hB, 0, 0, 0);
    step(1, 4'h0, 0, 0, 0);
    chk("count_two", 32'(digit_count), 32'd2);
    step(0, 4'h0, 1, 0, 0);
    chk("count_cleared", 32'(digit_count), 32'd0);
    enter(16'hB0B1);
    chk("grant_after_clear", 32'(access_granted), 32'd1);
    chk("att_after_clear", 32'(attempts_left), 32'd3);
    idle();
    step(1, 4'hB, 0, 0, 0);
    step(1, 4'h0, 1, 0, 0);
    chk("clear_wins", 32'(digit_count), 32'd0);

    // Code change to 1234
    enter(16'hB0B1);
    step(0, 4'h0, 0, 1, 0);
    enter(16'h1234);
    chk("code_updated", 32'(code_updated), 32'd1);
    enter(16'hB0B1);
    chk("old_code_rejected", 32'(error), 32'd1);
    enter(16'h1234);
    chk("new_code_grant", 32'(access_granted), 32'd1);
    idle();

    // Reset during lockout reverts code and counters
    enter(16'h0000);
    enter(16'h0000);
    enter(16'h0000);
    for (int k = 0; k < 40 && e_lrem != 9; k++) idle();
    chk("lrem_before_reset", 32'(lock_remaining), 32'd9);
    step(0, 4'h0, 0, 0, 1);
    chk("reset_in_lock_locked", 32'(locked), 32'd0);
    chk("reset_in_lock_lrem", 32'(lock_remaining), 32'd0);
    chk("reset_in_lock_att", 32'(attempts_left), 32'd3);
    enter(16'hB0B1);
    chk("default_code_restored", 32'(access_granted), 32'd1);

    // Reset during code change after two digits
    step(0, 4'h0, 0, 1, 0);
    step(1, 4'h5, 0, 0, 0);
    step(1, 4'h6, 0, 0, 0);
    chk("newcode_count", 32'(digit_count), 32'd2);
    step(0, 4'h0, 0, 0, 1);
    chk("reset_in_change_count", 32'(digit_count), 32'd0);
    enter(16'hB0B1);
    chk("code_kept_after_reset", 32'(access_granted), 32'd1);

    // Aborted code change keeps the old code
    step(0, 4'h0, 0, 1, 0);
    step(1, 4'h9, 0, 0, 0);
    step(0, 4'h0, 1, 0, 0);
    enter(16'hB0B1);
    chk("abort_keeps_code", 32'(access_granted), 32'd1);
    idle();

    // Success reloads attempts; two further failures do not lock
    enter(16'h0000);
    enter(16'h0000);
    enter(16'hB0B1);
    chk("reload_att", 32'(attempts_left), 32'd3);
    idle();
    enter(16'h0000);
    enter(16'h0000);
    chk("no_lock_att", 32'(attempts_left), 32'd1);
    chk("no_lock", 32'(locked), 32'd0);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
